// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 34-cycle multiply/divide producing {HI, LO} for the register file double-write port
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                op,
    input  logic [DATA_WIDTH-1:0]     src_a,
    input  logic [DATA_WIDTH-1:0]     src_b,
    input  logic                      cancel,
    output logic                      busy,
    output logic                      double_en,
    output logic [2*DATA_WIDTH-1:0]   double_wdata
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dbz_q, dbz_d;
    logic [W-1:0]    m_q, m_d, hi_q, hi_d, lo_q, lo_d;
    logic            busy_q, busy_d, den_q, den_d;
    logic [2*W-1:0]  wdata_q, wdata_d;

    logic            signed_op, ge;
    logic [W-1:0]    a_abs, b_abs, diff, quo, rem;
    logic [W:0]      sum, trial;
    logic [2*W-1:0]  prod, result;

    always_comb begin
        signed_op = ~op[0];
        a_abs     = (signed_op && src_a[W-1]) ? -src_a : src_a;
        b_abs     = (signed_op && src_b[W-1]) ? -src_b : src_b;
        // multiply: add multiplicand into the upper half, then shift the whole accumulator right
        sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        // divide: shift next dividend bit into the partial remainder and try subtracting the divisor
        trial     = {hi_q, lo_q[W-1]};
        ge        = trial >= {1'b0, m_q};
        diff      = trial[W-1:0] - m_q;
        prod      = {hi_q, lo_q};
        quo       = dbz_q ? '1 : (neg_q ? -lo_q : lo_q);
        rem       = rneg_q ? -hi_q : hi_q;
        result    = is_div_q ? {rem, quo} : (neg_q ? -prod : prod);
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        dbz_d     = dbz_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        den_d     = den_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: if (start) begin
                is_div_d = op[1];
                neg_d    = signed_op & (src_a[W-1] ^ src_b[W-1]);
                rneg_d   = signed_op & src_a[W-1];
                dbz_d    = op[1] && (src_b == '0);
                m_d      = op[1] ? b_abs : a_abs;
                lo_d     = op[1] ? a_abs : b_abs;
                hi_d     = '0;
                cnt_d    = '0;
                busy_d   = 1'b1;
                state_d  = CALC;
            end
            CALC: begin
                hi_d    = is_div_q ? (ge ? diff : trial[W-1:0]) : sum[W:1];
                lo_d    = is_div_q ? {lo_q[W-2:0], ge} : {sum[0], lo_q[W-1:1]};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(W-1)) ? FIX : CALC;
            end
            FIX: begin
                wdata_d = result;
                den_d   = 1'b1;
                state_d = DONE;
            end
            default: begin
                den_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
        if (cancel) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            den_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            den_q    <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dbz_q    <= dbz_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            den_q    <= den_d;
            wdata_q  <= wdata_d;
        end
    end

    assign busy         = busy_q;
    assign double_en    = den_q;
    assign double_wdata = wdata_q;
endmodule
